// File: rtl/twiddle_gen.sv
// Streaming W_N^k generator for one radix-2 FFT stage using a quarter-wave cosine table.
// First factor one cycle after start, registered outputs; while out_valid & !out_ready everything holds.
module twiddle_gen #(
    parameter int LOG2N = 4,
    parameter int W     = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          stage,
    input  logic                abort,
    input  logic                out_ready,
    output logic                out_valid,
    output logic signed [W-1:0] tw_re,
    output logic signed [W-1:0] tw_im,
    output logic [LOG2N-2:0]    tw_idx,
    output logic                last,
    output logic                busy
);
    localparam int KW = LOG2N - 1;
    localparam int N  = 1 << LOG2N;
    localparam int Q  = N / 4;
    localparam logic [KW-1:0] QK     = KW'(Q);
    localparam logic [KW:0]   HALF_N = (KW+1)'(N / 2);

    typedef enum logic {IDLE, RUN} state_t;

    // Ceiling with a small tolerance so cos(pi/2) rounding noise still yields 0.
    function automatic logic [W-2:0] tab_val(input int m);
        real x;
        int  i;
        x = real'(1 << (W - 2)) * $cos(2.0 * 3.14159265358979323846 * real'(m) / real'(N));
        i = $rtoi(x);
        if (x - real'(i) > 1.0e-6) begin
            i = i + 1;
        end
        return (W-1)'(i);
    endfunction

    logic [W-2:0] w_tab [0:Q];
    genvar g;
    generate
        for (g = 0; g <= Q; g++) begin : g_tab
            assign w_tab[g] = tab_val(g);
        end
    endgenerate

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_stage;
    logic [KW-1:0]         r_idx;
    logic                  r_last;
    logic signed [W-1:0]   r_re, r_im;

    logic                  w_load, w_step, w_clear;
    logic [3:0]            w_clamp;
    logic [KW:0]           w_stride, w_adv;
    logic [KW-1:0]         w_k_nxt, w_m;
    logic                  w_last_nxt;
    logic signed [W-1:0]   w_re_nxt, w_im_nxt;

    assign w_clamp  = (stage >= 4'(LOG2N)) ? 4'(LOG2N - 1) : stage;
    assign w_stride = (KW+1)'(1) << r_stage;
    assign w_adv    = {1'b0, r_idx} + w_stride;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_clear     = 1'b1;
                end else if (out_ready) begin
                    if (!r_last) begin
                        w_step = 1'b1;
                    end else if (start) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_clear     = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_k_nxt    = w_load ? '0 : w_adv[KW-1:0];
        w_last_nxt = w_load ? (w_clamp == 4'(LOG2N - 1)) : ((w_adv + w_stride) == HALF_N);
        w_m        = w_k_nxt - QK;
        if (w_k_nxt < QK) begin
            w_re_nxt = $signed({1'b0, w_tab[w_k_nxt]});
            w_im_nxt = -$signed({1'b0, w_tab[QK - w_k_nxt]});
        end else begin
            w_re_nxt = -$signed({1'b0, w_tab[QK - w_m]});
            w_im_nxt = -$signed({1'b0, w_tab[w_m]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_re    <= '0;
            r_im    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_stage <= w_clamp;
            end
            if (w_load || w_step) begin
                r_idx  <= w_k_nxt;
                r_last <= w_last_nxt;
                r_re   <= w_re_nxt;
                r_im   <= w_im_nxt;
            end else if (w_clear) begin
                r_idx  <= '0;
                r_last <= 1'b0;
                r_re   <= '0;
                r_im   <= '0;
            end
        end
    end

    assign out_valid = (r_state == RUN);
    assign busy      = (r_state == RUN);
    assign tw_re     = r_re;
    assign tw_im     = r_im;
    assign tw_idx    = r_idx;
    assign last      = r_last;
endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: trig-based reference model, random stages and backpressure.
module tb_twiddle_gen;
    localparam int LOG2N = 4;
    localparam int W     = 13;
    localparam int N     = 1 << LOG2N;
    localparam real SCALE = 2048.0;
    localparam real PI    = 3.14159265358979323846;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [3:0]        stage;
    logic              abort;
    logic              out_ready;
    logic              out_valid;
    logic signed [W-1:0] tw_re;
    logic signed [W-1:0] tw_im;
    logic [LOG2N-2:0]  tw_idx;
    logic              last;
    logic              busy;

    twiddle_gen #(.LOG2N(LOG2N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stage     (stage),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .tw_idx    (tw_idx),
        .last      (last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k;
        int re;
        int im;
        int lst;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Magnitude scaled to 2^(W-2), rounded up, ignoring floating-point dust.
    function automatic int mag(input real v);
        real x;
        int  i;
        x = v * SCALE;
        i = $rtoi(x);
        if (x - real'(i) > 1.0e-6) i = i + 1;
        return i;
    endfunction

    function automatic int ref_re(input int k);
        real c;
        c = $cos(2.0 * PI * real'(k) / real'(N));
        return (c >= 0.0) ? mag(c) : -mag(-c);
    endfunction

    function automatic int ref_im(input int k);
        return -mag($sin(2.0 * PI * real'(k) / real'(N)));
    endfunction

    task automatic push_stage(input int s);
        int sc, stride, cnt;
        exp_t e;
        sc     = (s >= LOG2N) ? LOG2N - 1 : s;
        stride = 1 << sc;
        cnt    = (N / 2) / stride;
        for (int i = 0; i < cnt; i++) begin
            e.k   = i * stride;
            e.re  = ref_re(e.k);
            e.im  = ref_im(e.k);
            e.lst = (i == cnt - 1) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    // Monitor: pops on every accepted element and checks that stalled outputs hold.
    logic p_stall = 1'b0;
    int   p_snap  = 0;
    always @(negedge clk) begin
        exp_t e;
        int   snap;
        snap = {tw_re, tw_im, tw_idx, last, out_valid};
        if (!rst_n) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) chk("stall_hold", snap, p_snap);
            if (out_valid && out_ready && !abort) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tw_idx", int'(tw_idx), e.k);
                    chk("tw_re", int'(tw_re), e.re);
                    chk("tw_im", int'(tw_im), e.im);
                    chk("last", int'(last), e.lst);
                end
            end
            p_stall = out_valid && !out_ready && !abort;
            p_snap  = snap;
        end
    end

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_stage(input int s, input int mode);
        int cyc;
        cyc       = 0;
        stage     = 4'(s);
        start     = 1'b1;
        out_ready = pick_ready(mode, 0);
        push_stage(s);
        @(posedge clk); #1;
        start = 1'b0;
        while (busy && cyc < 300) begin
            out_ready = pick_ready(mode, cyc);
            @(posedge clk); #1;
            cyc++;
        end
        chk("seq_done_busy", int'(busy), 0);
        chk("idle_valid", int'(out_valid), 0);
        chk("idle_last", int'(last), 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int cyc;
        bit chained;
        rst_n = 1'b0; start = 1'b0; stage = 4'd0; abort = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_re", int'(tw_re), 0);
        chk("rst_im", int'(tw_im), 0);
        chk("rst_idx", int'(tw_idx), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_stage(0, 0);
        run_stage(1, 1);
        run_stage(3, 0);
        run_stage(9, 0);

        // Back-to-back: start on the final handshake of stage 2.
        cyc = 0; chained = 1'b0;
        stage = 4'd2; start = 1'b1; out_ready = 1'b1; push_stage(2);
        @(posedge clk); #1; start = 1'b0;
        while (busy && cyc < 100) begin
            if (out_valid && last && !chained) begin
                chained = 1'b1;
                stage = 4'd1; start = 1'b1; push_stage(1);
                @(posedge clk); #1; start = 1'b0; cyc++;
                chk("chain_valid", int'(out_valid), 1);
                chk("chain_busy", int'(busy), 1);
                chk("chain_idx", int'(tw_idx), 0);
            end else begin
                @(posedge clk); #1; cyc++;
            end
        end
        chk("chain_happened", int'(chained), 1);
        chk("chain_done", int'(busy), 0);
        chk("chain_sb", sb.size(), 0);

        // Abort on the third element of stage 0, with start also high.
        stage = 4'd0; start = 1'b1; out_ready = 1'b1; push_stage(0);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_idx", int'(tw_idx), 2);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sb_left", sb.size(), 6);
        sb.delete();
        @(posedge clk); #1;
        chk("abort_no_restart", int'(busy), 0);

        // Asynchronous reset mid-sequence.
        stage = 4'd0; start = 1'b1; out_ready = 1'b1; push_stage(0);
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_re", int'(tw_re), 0);
        chk("mid_rst_im", int'(tw_im), 0);
        chk("mid_rst_idx", int'(tw_idx), 0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", int'(out_valid), 0);
        run_stage(0, 2);

        for (int t = 0; t < 12; t++) begin
            run_stage(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end
endmodule

// File: doc/twiddle_gen.md
# twiddle_gen

Parametrised streaming twiddle-factor generator for the radix-2 FFT datapath. It produces the complex factors W_N^k = cos(2πk/N) − j·sin(2πk/N) for one FFT stage, in the order the butterfly unit consumes them. Data leaves on a valid/ready stream. It generalises the fixed 8-entry 16-point imaginary-part ROM to any power-of-two N, both real and imaginary outputs, and stage-dependent stride, and stores only a quarter-wave cosine table.

## Interface
- LOG2N, default 4: log2 of FFT size N; legal range 3..12.
- W, default 13: signed output width; 1.0 is represented as 2^(W-2) (2048 at W=13).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to generate one stage sequence; sampled on the clock edge.
- stage  in  4  FFT stage s, sampled with start; values ≥ LOG2N are clamped to LOG2N−1.
- abort  in  1  synchronous abort of the running sequence.
- out_ready  in  1  downstream accepts the current output.
- out_valid  out  1  tw_re, tw_im, tw_idx and last are valid.
- tw_re  out  W  signed cos(2πk/N)·2^(W-2).
- tw_im  out  W  signed −sin(2πk/N)·2^(W-2).
- tw_idx  out  LOG2N−1  current index k, where 0 ≤ k < N/2.
- last  out  1  marks the final element of the sequence.
- busy  out  1  a sequence is in progress.

## Operation
- Quarter-wave table T[m], m = 0..N/4, unsigned, W−1 bits.
  - T[m] = ceil(2^(W-2)·cos(2πm/N)), computed at elaboration.
  - At LOG2N=4, W=13: T = 2048, 1893, 1449, 784, 0. These match the existing 16-point ROM values.
- Symmetry mapping for k < N/4:
  - re = +T[k]
  - im = −T[N/4−k]
- Symmetry mapping for k ≥ N/4, with m = k−N/4:
  - re = −T[N/4−m]
  - im = −T[m]
- Negation cannot overflow, because magnitudes are ≤ 2^(W-2).
- Stage s sequence:
  - stride = 2^s, count = N/2^(s+1).
  - k = i·2^s for i = 0..count−1.
  - last = 1 only when i = count−1.
- FSM has two states, IDLE and RUN.
  - IDLE → RUN on start=1; stage is latched.
  - RUN → IDLE on a handshake (out_valid & out_ready) with last=1, or on abort=1.
  - start is ignored in RUN, except on the edge of the final handshake (see Timing).
- Stall rule: while out_valid=1 and out_ready=0, all outputs hold stable.
- abort takes priority over start and over the handshake. On abort, the current element is dropped, even if a handshake occurs in the same cycle.
- Reset values:
  - out_valid=0, busy=0, last=0.
  - tw_re=0, tw_im=0, tw_idx=0.
  - FSM in IDLE, index counter 0.
- Reset asserted mid-sequence returns the block to these values immediately, with no residual output after release.

## Timing
- Latency: start sampled at edge T in IDLE → at T+1, out_valid=1, busy=1, k=0 with its factors.
- Outputs are registered. Each handshake edge advances to the next k, valid from the following cycle. Throughput is one element per cycle while out_ready=1.
- Final handshake at edge T with start=0 → at T+1, out_valid=0, busy=0, last=0.
- Final handshake at edge T with start=1 → at T+1, the first element of the new sequence (new stage) is valid. There is no bubble and busy stays 1.
- abort at edge T → at T+1, out_valid=0, busy=0. If start is also 1, it is ignored.
- Single-element sequence (s = LOG2N−1): first cycle carries k=0, last=1, re=2^(W-2), im=0.
- out_ready may be high while out_valid=0; this has no effect.

## Test plan
- Reset, then LOG2N=4/W=13, stage=0, out_ready=1 → 8 consecutive outputs, last on the 8th, then out_valid=0 and busy=0:
  - tw_im = 0, −784, −1449, −1893, −2048, −1893, −1449, −784
  - tw_re = 2048, 1893, 1449, 784, 0, −784, −1449, −1893
- stage=1, out_ready toggling 1,0,0,1,... → k = 0, 2, 4, 6 in that order, each held stable while stalled:
  - re = 2048, 1449, 0, −1449
  - im = 0, −1449, −2048, −1449
- stage=3, then stage=9 (clamped to 3) → one output each: k=0, re=2048, im=0, last=1.
- start asserted on the final handshake of stage 2 (k = 0, 4) → next cycle valid with k=0 of the new stage, with no out_valid gap.
- abort during the 3rd element of stage 0, with start=1 in the same cycle → next cycle out_valid=0 and busy=0, and no new sequence starts.
- rst_n pulled low mid-sequence → all outputs 0 asynchronously. After release, start with stage=0 begins again at k=0.
